// File: rtl/onchip_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onchip_memory_arbiter
// Purpose  : Two-master Avalon-MM arbiter in front of one single-port RAM,
//            round-robin with bounded hold and fixed 1-cycle read latency.
// Revision : 1.0  initial release
// ============================================================================
module onchip_memory_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 32000,
    parameter int MAX_HOLD  = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int HC_W = $clog2(MAX_HOLD + 1);

    localparam logic [ADDR_W:0] c_num_words = (ADDR_W + 1)'(NUM_WORDS);
    localparam logic [HC_W-1:0] c_max_hold  = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] c_hold_one  = HC_W'(1);

    logic              w_req0;
    logic              w_req1;
    logic              w_both;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [BE_W-1:0]   w_sel_be;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_read;
    logic              w_sel_write;
    logic              w_in_range;
    logic              w_rd_accept;
    logic [DATA_W-1:0] w_rdata;

    logic              r_last_grant;   // 0 = m0, 1 = m1
    logic [HC_W-1:0]   r_hold_cnt;
    logic              r_rdv0;
    logic              r_rdv1;
    logic              r_rd_oor;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;
    assign w_both = w_req0 & w_req1;

    // A hold count of zero means the current contention has no streak yet, so
    // the master that did not go last wins; this gives m0 the first tie.
    always_comb begin
        w_gnt1 = w_req1;
        if (w_both) begin
            if ((r_hold_cnt != '0) && (r_hold_cnt < c_max_hold)) begin
                w_gnt1 = r_last_grant;
            end else begin
                w_gnt1 = ~r_last_grant;
            end
        end
    end

    assign w_gnt0   = w_req0 & ~w_gnt1;
    assign w_accept = w_req0 | w_req1;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        w_sel_read  = 1'b0;
        w_sel_write = 1'b0;
        if (w_gnt1) begin
            w_sel_addr  = m1_address;
            w_sel_be    = m1_byteenable;
            w_sel_wdata = m1_writedata;
            w_sel_read  = m1_read;
            w_sel_write = m1_write;
        end else if (w_gnt0) begin
            w_sel_addr  = m0_address;
            w_sel_be    = m0_byteenable;
            w_sel_wdata = m0_writedata;
            w_sel_read  = m0_read;
            w_sel_write = m0_write;
        end
    end

    assign w_in_range  = ({1'b0, w_sel_addr} < c_num_words);
    assign w_rd_accept = w_accept & w_sel_read & ~w_sel_write;

    assign mem_address    = w_sel_addr;
    assign mem_byteenable = w_sel_be;
    assign mem_writedata  = w_sel_wdata;
    assign mem_chipselect = w_accept & w_in_range;
    assign mem_write      = w_accept & w_sel_write & w_in_range;

    assign m0_waitrequest = w_req0 & ~w_gnt0;
    assign m1_waitrequest = w_req1 & ~w_gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_hold_cnt   <= '0;
            r_rdv0       <= 1'b0;
            r_rdv1       <= 1'b0;
            r_rd_oor     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_gnt1;
            end
            if (w_both) begin
                if (w_gnt1 == r_last_grant) begin
                    r_hold_cnt <= (r_hold_cnt == c_max_hold) ? c_max_hold
                                                             : r_hold_cnt + c_hold_one;
                end else begin
                    r_hold_cnt <= c_hold_one;
                end
            end else begin
                r_hold_cnt <= '0;
            end
            r_rdv0 <= w_rd_accept & w_gnt0;
            r_rdv1 <= w_rd_accept & w_gnt1;
            if (w_rd_accept) begin
                r_rd_oor <= ~w_in_range;
            end
        end
    end

    // RAM output is already aligned with the registered valid; only the
    // out-of-range case needs masking.
    assign w_rdata = r_rd_oor ? '0 : mem_readdata;

    assign m0_readdata      = w_rdata;
    assign m1_readdata      = w_rdata;
    assign m0_readdatavalid = r_rdv0;
    assign m1_readdatavalid = r_rdv1;

endmodule
`default_nettype wire
